axi_sram_slv: RTL and testbench



---
 rtl/axi_sram_slv.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_sram_slv.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slv.sv
// AXI4 slave in front of a single-port synchronous SRAM (1-cycle read latency).
// Reads and writes are serialised onto the one SRAM port; FIXED and INCR bursts.
package axi_sram_pkg;
    typedef struct packed {
        logic [3:0]  aw_id;
        logic [31:0] aw_addr;
        logic [7:0]  aw_len;
        logic [2:0]  aw_size;
        logic [1:0]  aw_burst;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_last;
        logic        w_valid;
        logic        b_ready;
        logic [3:0]  ar_id;
        logic [31:0] ar_addr;
        logic [7:0]  ar_len;
        logic [2:0]  ar_size;
        logic [1:0]  ar_burst;
        logic        ar_valid;
        logic        r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic [3:0]  b_id;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic        ar_ready;
        logic [3:0]  r_id;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        r_valid;
    } axi_rsp_t;
endpackage

module axi_sram_slv #(
    parameter int  AddrWidth = 32,
    parameter int  DataWidth = 32,
    parameter int  IdWidth   = 4,
    parameter int  MemBytes  = 65536,
    parameter type axi_req_t = axi_sram_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_sram_pkg::axi_rsp_t,
    localparam int MemAddrWidth = $clog2(MemBytes / 4)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  axi_req_t                axi_req_i,
    output axi_rsp_t                axi_rsp_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [31:0]             mem_wdata_o,
    output logic [3:0]              mem_be_o,
    input  logic [31:0]             mem_rdata_i
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_WRESP = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [AddrWidth:0]   MemLimit = (AddrWidth + 1)'(MemBytes);
    localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);

    function automatic logic [1:0] beat_check(input logic [1:0] burst, input logic [2:0] size,
                                              input logic [AddrWidth-1:0] addr);
        if (burst == BURST_WRAP || size > 3'd2) begin
            return RESP_SLVERR;
        end else if ({1'b0, addr} >= MemLimit) begin
            return RESP_DECERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    // Response codes are ordered so that the numerically larger one is the more severe.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [1:0]           state_r;
    logic                 wr_first_r;
    logic [IdWidth-1:0]   id_r;
    logic [AddrWidth-1:0] addr_r;
    logic [7:0]           len_r;
    logic [2:0]           size_r;
    logic [1:0]           burst_r;
    logic [8:0]           beat_r;
    logic [1:0]           err_r;
    logic                 iss_done_r;
    logic                 r_valid_r;
    logic                 fresh_r;
    logic [DataWidth-1:0] r_data_r;
    logic [1:0]           r_resp_r;
    logic                 r_last_r;

    logic [1:0]           chk_s;
    logic [AddrWidth-1:0] addr_next_s;
    logic                 grant_w_s, grant_r_s, aw_hs_s, ar_hs_s, w_hs_s;
    logic                 in_len_s, short_s, r_issue_s, w_mem_s;
    logic [1:0]           w_err_s;
    logic [31:0]          r_data_s;

    assign chk_s       = beat_check(burst_r, size_r, addr_r);
    assign addr_next_s = (burst_r == 2'b00) ? addr_r : addr_r + (AddrOne << size_r);
    assign grant_w_s   = axi_req_i.aw_valid && (!axi_req_i.ar_valid || wr_first_r);
    assign grant_r_s   = axi_req_i.ar_valid && !grant_w_s;
    assign aw_hs_s     = (state_r == ST_IDLE) && grant_w_s;
    assign ar_hs_s     = (state_r == ST_IDLE) && grant_r_s;
    assign w_hs_s      = (state_r == ST_WRITE) && axi_req_i.w_valid;
    assign in_len_s    = beat_r <= {1'b0, len_r};
    assign short_s     = axi_req_i.w_last && (beat_r < {1'b0, len_r});
    assign w_err_s     = resp_max(chk_s, (in_len_s && !short_s) ? RESP_OKAY : RESP_SLVERR);
    assign r_issue_s   = (state_r == ST_READ) && !iss_done_r && (!r_valid_r || axi_req_i.r_ready);
    assign w_mem_s     = w_hs_s && in_len_s && (chk_s == RESP_OKAY);
    // Read data bypasses the holding register in the cycle it arrives from the SRAM.
    assign r_data_s    = fresh_r ? ((r_resp_r == RESP_OKAY) ? mem_rdata_i : 32'h0) : r_data_r;

    assign mem_req_o   = (r_issue_s && (chk_s == RESP_OKAY)) || w_mem_s;
    assign mem_we_o    = (state_r == ST_WRITE);
    assign mem_addr_o  = addr_r[MemAddrWidth+1:2];
    assign mem_wdata_o = axi_req_i.w_data;
    assign mem_be_o    = axi_req_i.w_strb;

    // AXI response channel assembly.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_hs_s;
        axi_rsp_o.ar_ready = ar_hs_s;
        axi_rsp_o.w_ready  = (state_r == ST_WRITE);
        axi_rsp_o.b_valid  = (state_r == ST_WRESP);
        axi_rsp_o.b_id     = id_r;
        axi_rsp_o.b_resp   = err_r;
        axi_rsp_o.r_valid  = r_valid_r;
        axi_rsp_o.r_id     = id_r;
        axi_rsp_o.r_data   = r_data_s;
        axi_rsp_o.r_resp   = r_resp_r;
        axi_rsp_o.r_last   = r_last_r;
    end

    // Transaction FSM, burst tracking and R holding registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            wr_first_r <= 1'b1;
            id_r       <= '0;
            addr_r     <= '0;
            len_r      <= 8'h0;
            size_r     <= 3'h0;
            burst_r    <= 2'h0;
            beat_r     <= 9'h0;
            err_r      <= RESP_OKAY;
            iss_done_r <= 1'b0;
            r_valid_r  <= 1'b0;
            fresh_r    <= 1'b0;
            r_data_r   <= '0;
            r_resp_r   <= RESP_OKAY;
            r_last_r   <= 1'b0;
        end else begin
            fresh_r <= 1'b0;
            if (fresh_r) begin
                r_data_r <= r_data_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (aw_hs_s) begin
                        id_r       <= axi_req_i.aw_id;
                        addr_r     <= axi_req_i.aw_addr;
                        len_r      <= axi_req_i.aw_len;
                        size_r     <= axi_req_i.aw_size;
                        burst_r    <= axi_req_i.aw_burst;
                        beat_r     <= 9'h0;
                        err_r      <= RESP_OKAY;
                        wr_first_r <= ~wr_first_r;
                        state_r    <= ST_WRITE;
                    end else if (ar_hs_s) begin
                        id_r       <= axi_req_i.ar_id;
                        addr_r     <= axi_req_i.ar_addr;
                        len_r      <= axi_req_i.ar_len;
                        size_r     <= axi_req_i.ar_size;
                        burst_r    <= axi_req_i.ar_burst;
                        beat_r     <= 9'h0;
                        err_r      <= RESP_OKAY;
                        iss_done_r <= 1'b0;
                        wr_first_r <= ~wr_first_r;
                        state_r    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_issue_s) begin
                        r_valid_r <= 1'b1;
                        fresh_r   <= 1'b1;
                        r_resp_r  <= chk_s;
                        r_last_r  <= (beat_r[7:0] == len_r);
                        beat_r    <= beat_r + 9'd1;
                        addr_r    <= addr_next_s;
                        if (beat_r[7:0] == len_r) begin
                            iss_done_r <= 1'b1;
                        end
                    end else if (r_valid_r && axi_req_i.r_ready) begin
                        r_valid_r <= 1'b0;
                        if (r_last_r) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_hs_s) begin
                        if (beat_r != 9'h1FF) begin
                            beat_r <= beat_r + 9'd1;
                        end
                        addr_r <= addr_next_s;
                        err_r  <= resp_max(err_r, w_err_s);
                        if (axi_req_i.w_last) begin
                            state_r <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (axi_req_i.b_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slv.sv
// Directed bench for axi_sram_slv with a behavioural 1-cycle-latency SRAM model.
module tb_axi_sram_slv;
    import axi_sram_pkg::*;

    logic        clk;
    logic        rst_n;
    axi_req_t    req;
    axi_rsp_t    rsp;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic [31:0] sram [0:16383];
    logic [13:0] rd_log [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [13:0] last_wr_addr = 14'h0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    axi_sram_slv dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .axi_req_i  (req),
        .axi_rsp_o  (rsp),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_be_o   (mem_be),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model and access log.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
                wr_cnt       = wr_cnt + 1;
                last_wr_addr = mem_addr;
            end else begin
                mem_rdata          <= sram[mem_addr];
                rd_log[rd_cnt % 256] = mem_addr;
                rd_cnt             = rd_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        bit ok = 0;
        req.aw_id = id; req.aw_addr = addr; req.aw_len = len; req.aw_size = 3'd2;
        req.aw_burst = burst; req.aw_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rsp.aw_ready) ok = 1;
            @(posedge clk); #1;
        end
        req.aw_valid = 1'b0;
        check("aw_handshake", 64'(ok), 64'd1);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 0;
        req.ar_id = id; req.ar_addr = addr; req.ar_len = len; req.ar_size = 3'd2;
        req.ar_burst = 2'b01; req.ar_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rsp.ar_ready) ok = 1;
            @(posedge clk); #1;
        end
        req.ar_valid = 1'b0;
        check("ar_handshake", 64'(ok), 64'd1);
    endtask

    task automatic w_send(input logic [31:0] data, input logic last);
        bit ok = 0;
        req.w_data = data; req.w_strb = 4'hF; req.w_last = last; req.w_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rsp.w_ready) ok = 1;
            @(posedge clk); #1;
        end
        req.w_valid = 1'b0;
        check("w_handshake", 64'(ok), 64'd1);
    endtask

    task automatic b_recv(input logic [3:0] id, input logic [1:0] resp);
        bit ok = 0;
        req.b_ready = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rsp.b_valid) begin
                ok = 1;
                check("b_id", 64'(rsp.b_id), 64'(id));
                check("b_resp", 64'(rsp.b_resp), 64'(resp));
            end
            @(posedge clk); #1;
        end
        req.b_ready = 1'b0;
        check("b_seen", 64'(ok), 64'd1);
    endtask

    task automatic r_recv(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                          input logic last);
        bit ok = 0;
        req.r_ready = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rsp.r_valid) begin
                ok = 1;
                check("r_id", 64'(rsp.r_id), 64'(id));
                check("r_data", 64'(rsp.r_data), 64'(data));
                check("r_resp", 64'(rsp.r_resp), 64'(resp));
                check("r_last", 64'(rsp.r_last), 64'(last));
            end
            @(posedge clk); #1;
        end
        req.r_ready = 1'b0;
        check("r_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        logic [31:0] exp_burst [0:3];
        int w0, r0, beat, cyc;
        bit ok;
        for (int i = 0; i < 4; i++) exp_burst[i] = 32'hA5A5_0000 + 32'(i);
        req   = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", 64'(rsp.aw_ready), 64'd0);
        check("rst_ar_ready", 64'(rsp.ar_ready), 64'd0);
        check("rst_w_ready", 64'(rsp.w_ready), 64'd0);
        check("rst_b_valid", 64'(rsp.b_valid), 64'd0);
        check("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        check("rst_r_data", 64'(rsp.r_data), 64'd0);
        check("rst_resp", 64'({rsp.b_resp, rsp.r_resp}), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        rst_n = 1'b1;

        // Single write then read back.
        w0 = wr_cnt;
        aw_send(4'd3, 32'h10, 8'd0, 2'b01);
        w_send(32'hDEAD_BEEF, 1'b1);
        b_recv(4'd3, 2'b00);
        check("single_wr_count", 64'(wr_cnt - w0), 64'd1);
        check("single_wr_addr", 64'(last_wr_addr), 64'd4);
        ar_send(4'd5, 32'h10, 8'd0);
        r_recv(4'd5, 32'hDEAD_BEEF, 2'b00, 1'b1);

        // Fill words 0x40..0x43, then read back with r_ready toggling 1,0,1,1.
        w0 = wr_cnt;
        aw_send(4'd6, 32'h100, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) w_send(exp_burst[i], i == 3);
        b_recv(4'd6, 2'b00);
        check("burst_wr_count", 64'(wr_cnt - w0), 64'd4);
        r0 = rd_cnt;
        ar_send(4'd7, 32'h100, 8'd3);
        beat = 0; cyc = 0;
        while (beat < 4 && cyc < 40) begin
            @(negedge clk);
            req.r_ready = (cyc % 4 != 1);
            if (rsp.r_valid) begin
                check("burst_r_data", 64'(rsp.r_data), 64'(exp_burst[beat]));
                check("burst_r_last", 64'(rsp.r_last), 64'(beat == 3));
                if (req.r_ready) beat++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        check("burst_beats", 64'(beat), 64'd4);
        check("burst_rd_count", 64'(rd_cnt - r0), 64'd4);
        for (int i = 0; i < 4; i++)
            check("burst_rd_addr", 64'(rd_log[(r0 + i) % 256]), 64'(14'h40 + 14'(i)));

        // Contested AW/AR: write first out of reset, then read wins the next contest.
        req.aw_id = 4'd1; req.aw_addr = 32'h20; req.aw_len = 8'd0; req.aw_size = 3'd2;
        req.aw_burst = 2'b01; req.aw_valid = 1'b1;
        req.ar_id = 4'd2; req.ar_addr = 32'h20; req.ar_len = 8'd0; req.ar_size = 3'd2;
        req.ar_burst = 2'b01; req.ar_valid = 1'b1;
        @(negedge clk);
        check("arb1_aw_ready", 64'(rsp.aw_ready), 64'd1);
        check("arb1_ar_ready", 64'(rsp.ar_ready), 64'd0);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        w_send(32'h1122_3344, 1'b1);
        req.aw_id = 4'd8; req.aw_addr = 32'h24; req.aw_valid = 1'b1;
        b_recv(4'd1, 2'b00);
        @(negedge clk);
        check("arb2_ar_ready", 64'(rsp.ar_ready), 64'd1);
        check("arb2_aw_ready", 64'(rsp.aw_ready), 64'd0);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        r_recv(4'd2, 32'h1122_3344, 2'b00, 1'b1);
        aw_send(4'd8, 32'h24, 8'd0, 2'b01);
        w_send(32'h5566_7788, 1'b1);
        b_recv(4'd8, 2'b00);

        // Out-of-range read: DECERR beats, no SRAM access.
        r0 = rd_cnt; w0 = wr_cnt;
        ar_send(4'd9, 32'h0001_0000, 8'd1);
        r_recv(4'd9, 32'h0, 2'b11, 1'b0);
        r_recv(4'd9, 32'h0, 2'b11, 1'b1);
        check("decerr_no_mem", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);

        // WRAP write: data consumed, nothing written, SLVERR.
        aw_send(4'd10, 32'h30, 8'd1, 2'b10);
        w_send(32'h0BAD_0001, 1'b0);
        w_send(32'h0BAD_0002, 1'b1);
        b_recv(4'd10, 2'b10);
        check("wrap_no_write", 64'(wr_cnt - w0), 64'd0);

        // Early w_last, then surplus beats.
        w0 = wr_cnt;
        aw_send(4'd11, 32'h40, 8'd1, 2'b01);
        w_send(32'hCAFE_0000, 1'b1);
        b_recv(4'd11, 2'b10);
        check("short_wr_count", 64'(wr_cnt - w0), 64'd1);
        w0 = wr_cnt;
        aw_send(4'd12, 32'h44, 8'd0, 2'b01);
        w_send(32'hCAFE_0001, 1'b0);
        w_send(32'hCAFE_0002, 1'b0);
        w_send(32'hCAFE_0003, 1'b1);
        b_recv(4'd12, 2'b10);
        check("long_wr_count", 64'(wr_cnt - w0), 64'd1);
        check("long_wr_addr", 64'(last_wr_addr), 64'h11);

        // Reset during beat 1 of a 4-beat read, then a clean read.
        ar_send(4'd13, 32'h100, 8'd3);
        req.r_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rsp.r_valid) ok = 1;
        end
        check("mid_first_beat", 64'(ok), 64'd1);
        check("mid_beat0_data", 64'(rsp.r_data), 64'(exp_burst[0]));
        @(negedge clk);
        check("mid_beat1_data", 64'(rsp.r_data), 64'(exp_burst[1]));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_r_valid", 64'(rsp.r_valid), 64'd0);
        check("mid_rst_readies", 64'({rsp.aw_ready, rsp.ar_ready, rsp.w_ready}), 64'd0);
        check("mid_rst_b_valid", 64'(rsp.b_valid), 64'd0);
        check("mid_rst_mem_req", 64'(mem_req), 64'd0);
        rst_n = 1'b1;
        req.r_ready = 1'b0;
        ar_send(4'd14, 32'h104, 8'd0);
        r_recv(4'd14, exp_burst[1], 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
